// File: rtl/eth_hdr_pkg.sv
// rtl/eth_hdr_pkg.sv - sync-header constants, monitor FSM states and header classifier
package eth_hdr_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } hdr_mon_state_t;

   // Only the two transition patterns are legal 64b/66b sync headers.
   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones; clr wins over inc
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/serdes_hdr_err_monitor.sv
// rtl/serdes_hdr_err_monitor.sv - windowed valid/invalid sync-header counter with burst and high-BER result
module serdes_hdr_err_monitor
   import eth_hdr_pkg::*;
#(
   parameter int HDR_WIDTH    = 2,
   parameter int WINDOW_WIDTH = 16,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    rx_clk,
   input  logic                    rx_rst,
   input  logic [HDR_WIDTH-1:0]    serdes_rx_hdr,
   input  logic                    serdes_rx_hdr_valid,
   input  logic [WINDOW_WIDTH-1:0] cfg_window,
   input  logic [COUNT_WIDTH-1:0]  cfg_thresh,
   input  logic                    cfg_continuous,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [COUNT_WIDTH-1:0]  valid_count,
   output logic [COUNT_WIDTH-1:0]  invalid_count,
   output logic [COUNT_WIDTH-1:0]  max_burst,
   output logic                    high_ber
);

   hdr_mon_state_t          state_q, state_d;
   logic [WINDOW_WIDTH-1:0] win_q;
   logic [WINDOW_WIDTH-1:0] blk_q;
   logic                    cont_q;
   logic [COUNT_WIDTH-1:0]  valid_q, inv_q, run_q, burst_q;
   logic [COUNT_WIDTH-1:0]  valid_fin, inv_fin, run_fin, burst_fin;
   logic                    qual, hdr_ok, start_ok, win_end, cnt_clr;
   logic                    inc_valid, inc_inv;

   assign qual      = (state_q == RUN) && serdes_rx_hdr_valid;
   assign hdr_ok    = hdr_is_valid(serdes_rx_hdr[1:0]);
   assign start_ok  = (state_q == IDLE) && start && (cfg_window != '0);
   assign win_end   = qual && (blk_q == win_q - 1'b1);
   assign cnt_clr   = start_ok || win_end;
   assign inc_valid = qual && hdr_ok;
   assign inc_inv   = qual && !hdr_ok;
   assign busy      = (state_q == RUN);

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_valid_cnt (
      .clk(rx_clk), .rst(rx_rst), .inc(inc_valid), .clr(cnt_clr), .q(valid_q)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_inv_cnt (
      .clk(rx_clk), .rst(rx_rst), .inc(inc_inv), .clr(cnt_clr), .q(inv_q)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_run_cnt (
      .clk(rx_clk), .rst(rx_rst), .inc(inc_inv), .clr(cnt_clr || inc_valid), .q(run_q)
   );

   // Counts including the block on the current edge, so the closing block lands in the results.
   assign valid_fin = valid_q + COUNT_WIDTH'(inc_valid && (valid_q != '1));
   assign inv_fin   = inv_q + COUNT_WIDTH'(inc_inv && (inv_q != '1));
   assign run_fin   = run_q + COUNT_WIDTH'(inc_inv && (run_q != '1));
   assign burst_fin = (inc_inv && (run_fin > burst_q)) ? run_fin : burst_q;

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = RUN;
         RUN:     if (win_end && !cont_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         win_q   <= '0;
         cont_q  <= 1'b0;
         blk_q   <= '0;
         burst_q <= '0;
      end else begin
         if (start_ok) begin
            win_q  <= cfg_window;
            cont_q <= cfg_continuous;
         end
         if (cnt_clr) begin
            blk_q   <= '0;
            burst_q <= '0;
         end else begin
            if (qual) blk_q <= blk_q + 1'b1;
            burst_q <= burst_fin;
         end
      end
   end

   // cfg_thresh is deliberately taken live at window end so it can be retuned mid-window.
   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         done          <= 1'b0;
         valid_count   <= '0;
         invalid_count <= '0;
         max_burst     <= '0;
         high_ber      <= 1'b0;
      end else begin
         done <= win_end;
         if (win_end) begin
            valid_count   <= valid_fin;
            invalid_count <= inv_fin;
            max_burst     <= burst_fin;
            high_ber      <= (cfg_thresh != '0) && (inv_fin >= cfg_thresh);
         end
      end
   end

endmodule

// File: tb/tb_serdes_hdr_err_monitor.sv
// tb/tb_serdes_hdr_err_monitor.sv - directed/random bench for serdes_hdr_err_monitor with list-based reference
module tb_serdes_hdr_err_monitor;

   logic        clk_tb = 1'b0;
   logic        rx_rst_tb = 1'b1;
   logic [1:0]  hdr;
   logic        hdr_valid;
   logic [15:0] cfg_window;
   logic [15:0] cfg_thresh;
   logic [3:0]  cfg_thresh4;
   logic        cfg_continuous;
   logic        start;

   logic        busy, done, high_ber;
   logic [15:0] valid_count, invalid_count, max_burst;
   logic        busy4, done4, high_ber4;
   logic [3:0]  valid_count4, invalid_count4, max_burst4;

   int checks = 0;
   int errors = 0;
   logic [1:0] blk[$];

   always #5 clk_tb = ~clk_tb;

   serdes_hdr_err_monitor #(.HDR_WIDTH(2), .WINDOW_WIDTH(16), .COUNT_WIDTH(16)) dut (
      .rx_clk(clk_tb), .rx_rst(rx_rst_tb),
      .serdes_rx_hdr(hdr), .serdes_rx_hdr_valid(hdr_valid),
      .cfg_window(cfg_window), .cfg_thresh(cfg_thresh),
      .cfg_continuous(cfg_continuous), .start(start),
      .busy(busy), .done(done),
      .valid_count(valid_count), .invalid_count(invalid_count),
      .max_burst(max_burst), .high_ber(high_ber)
   );

   serdes_hdr_err_monitor #(.HDR_WIDTH(2), .WINDOW_WIDTH(16), .COUNT_WIDTH(4)) dut4 (
      .rx_clk(clk_tb), .rx_rst(rx_rst_tb),
      .serdes_rx_hdr(hdr), .serdes_rx_hdr_valid(hdr_valid),
      .cfg_window(cfg_window), .cfg_thresh(cfg_thresh4),
      .cfg_continuous(cfg_continuous), .start(start),
      .busy(busy4), .done(done4),
      .valid_count(valid_count4), .invalid_count(invalid_count4),
      .max_burst(max_burst4), .high_ber(high_ber4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   function automatic logic [1:0] rnd_ok();
      return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] rnd_bad();
      return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
   endfunction

   // Tally the block list, then clamp each figure to the counter width.
   task automatic model(input int cw, output int v, output int inv, output int mb);
      int run = 0;
      int lim = (1 << cw) - 1;
      v = 0; inv = 0; mb = 0;
      foreach (blk[i]) begin
         if (blk[i] == 2'b01 || blk[i] == 2'b10) begin
            v++;
            run = 0;
         end else begin
            inv++;
            run++;
            if (run > mb) mb = run;
         end
      end
      if (v > lim) v = lim;
      if (inv > lim) inv = lim;
      if (mb > lim) mb = lim;
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_on_start"}, busy, 1);
   endtask

   // Drive blk as one window; gap adds one idle cycle after each block; poke re-requests start mid-window.
   task automatic play(input string tag, input bit gap, input bit poke);
      int  n = blk.size();
      bit  early = 0;
      int  v, inv, mb;
      for (int i = 0; i < n; i++) begin
         hdr = blk[i];
         hdr_valid = 1'b1;
         if (poke && i == n / 2) start = 1'b1;
         tick();
         start = 1'b0;
         hdr_valid = 1'b0;
         if (i != n - 1 && done) early = 1;
         if (gap && i != n - 1) begin
            hdr = 2'($urandom_range(0, 3));
            tick();
            if (done) early = 1;
         end
      end
      model(16, v, inv, mb);
      chk({tag, "_early_done"}, early, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_valid"}, valid_count, v);
      chk({tag, "_invalid"}, invalid_count, inv);
      chk({tag, "_burst"}, max_burst, mb);
      chk({tag, "_high_ber"}, high_ber, (cfg_thresh != 0) && (inv >= cfg_thresh));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_valid"}, valid_count, 0);
      chk({tag, "_invalid"}, invalid_count, 0);
      chk({tag, "_burst"}, max_burst, 0);
      chk({tag, "_high_ber"}, high_ber, 0);
   endtask

   initial begin
      int v4, inv4, mb4;
      int pa, pb;
      hdr = 2'b00; hdr_valid = 1'b0; cfg_window = 16'd0; cfg_thresh = 16'd0;
      cfg_thresh4 = 4'd0; cfg_continuous = 1'b0; start = 1'b0;
      repeat (3) tick();
      rx_rst_tb = 1'b0;
      tick();
      chk_zero("reset");

      // all-good window; cfg_window changed and start re-pulsed mid-window must not matter
      cfg_window = 16'd100;
      do_start("t1");
      cfg_window = 16'd3;
      blk = {};
      for (int i = 0; i < 100; i++) blk.push_back(2'b10);
      play("t1", 0, 1);
      tick();
      chk("t1_busy_after", busy, 0);
      chk("t1_done_pulse", done, 0);

      // one error per ten blocks, thresh 5 then thresh 0
      cfg_window = 16'd100;
      cfg_thresh = 16'd5;
      blk = {};
      for (int i = 0; i < 100; i++) blk.push_back((i % 10 == 9) ? 2'b11 : rnd_ok());
      do_start("t2a");
      play("t2a", 0, 0);
      tick();
      cfg_thresh = 16'd0;
      do_start("t2b");
      play("t2b", 0, 0);
      tick();

      // burst of 7 split by idle cycles
      cfg_window = 16'd50;
      cfg_thresh = 16'd7;
      blk = {};
      for (int i = 0; i < 50; i++) blk.push_back((i >= 20 && i < 27) ? 2'b11 : rnd_ok());
      do_start("t3");
      play("t3", 1, 0);
      tick();

      // continuous: three back-to-back windows with 0, 2, 20 errors
      cfg_window = 16'd20;
      cfg_thresh = 16'd3;
      cfg_continuous = 1'b1;
      do_start("t4");
      cfg_continuous = 1'b0;
      blk = {};
      for (int i = 0; i < 20; i++) blk.push_back(rnd_ok());
      play("t4w0", 0, 0);
      chk("t4w0_busy", busy, 1);
      pa = $urandom_range(0, 9);
      pb = $urandom_range(10, 19);
      blk = {};
      for (int i = 0; i < 20; i++) blk.push_back((i == pa || i == pb) ? rnd_bad() : rnd_ok());
      play("t4w1", 1, 0);
      chk("t4w1_busy", busy, 1);
      blk = {};
      for (int i = 0; i < 20; i++) blk.push_back(rnd_bad());
      play("t4w2", 0, 0);
      chk("t4w2_busy", busy, 1);
      rx_rst_tb = 1'b1;
      #1;
      chk_zero("t4_rst");
      rx_rst_tb = 1'b0;
      tick();

      // saturation on the 4-bit instance
      cfg_window = 16'd40;
      blk = {};
      for (int i = 0; i < 40; i++) blk.push_back(2'b00);
      do_start("t5");
      play("t5", 0, 0);
      model(4, v4, inv4, mb4);
      chk("t5_sat_done", done4, 1);
      chk("t5_sat_valid", valid_count4, v4);
      chk("t5_sat_invalid", invalid_count4, inv4);
      chk("t5_sat_burst", max_burst4, mb4);
      chk("t5_sat_invalid_const", invalid_count4, 15);
      tick();

      // reset mid-window, then a clean window, then start with window 0
      cfg_window = 16'd100;
      do_start("t6");
      for (int i = 0; i < 30; i++) begin
         hdr = 2'($urandom_range(0, 3));
         hdr_valid = 1'b1;
         tick();
      end
      hdr_valid = 1'b0;
      rx_rst_tb = 1'b1;
      #1;
      chk_zero("t6_rst");
      rx_rst_tb = 1'b0;
      tick();
      cfg_window = 16'd20;
      blk = {};
      for (int i = 0; i < 20; i++) blk.push_back(2'($urandom_range(0, 3)));
      do_start("t6b");
      play("t6b", 1, 0);
      tick();
      cfg_window = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_win0_busy", busy, 0);
      tick();
      chk("t6_win0_busy2", busy, 0);
      chk("t6_win0_done", done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serdes_hdr_err_monitor.md
Name: serdes_hdr_err_monitor

Overview:
- Receive-side sync-header error monitor for the 10G PHY SerDes interface.
- Counterpart to the header noise-injection path: samples serdes_rx_hdr and classifies each 66b block header as valid (01/10) or invalid (00/11).
- Over a programmable window it counts valid headers, invalid headers and the longest run of consecutive invalid headers, then latches the results and a high-BER flag.
- Sits beside eth_phy_10g on rx_clk; used on hardware and in benches to measure injected header-error rate.

Parameters:
- HDR_WIDTH, 2, sync header width; only 2 supported.
- WINDOW_WIDTH, 16, width of cfg_window (blocks per window).
- COUNT_WIDTH, 16, width of all result counters; counters saturate at 2^COUNT_WIDTH-1.

Ports:
- rx_clk  in  1  clock.
- rx_rst  in  1  asynchronous, active-high reset.
- serdes_rx_hdr  in  HDR_WIDTH  sync header of the current block.
- serdes_rx_hdr_valid  in  1  header qualifier; only sampled when 1.
- cfg_window  in  WINDOW_WIDTH  blocks per measurement window; 0 = disabled.
- cfg_thresh  in  COUNT_WIDTH  invalid-count threshold for high_ber; 0 disables the flag.
- cfg_continuous  in  1  restart the next window automatically at window end.
- start  in  1  one-cycle request to begin a window.
- busy  out  1  window in progress.
- done  out  1  one-cycle pulse, results updated.
- valid_count  out  COUNT_WIDTH  latched valid-header count.
- invalid_count  out  COUNT_WIDTH  latched invalid-header count.
- max_burst  out  COUNT_WIDTH  latched longest consecutive-invalid run.
- high_ber  out  1  latched: cfg_thresh != 0 and invalid_count >= cfg_thresh.

Behaviour:
- Reset (async, rx_rst=1): state IDLE; busy, done, high_ber = 0; all counts, result registers and window counter = 0. Reset mid-window discards partial results.
- FSM states: IDLE, RUN.
- IDLE -> RUN when start=1 and cfg_window!=0. Working counters clear on entry.
  - start with cfg_window=0 is ignored.
  - start while in RUN is ignored.
- RUN, on each cycle with serdes_rx_hdr_valid=1:
  - header 01 or 10: valid counter +1; run counter clears.
  - header 00 or 11: invalid counter +1; run counter +1; burst max = max(burst max, run+1).
  - block counter +1.
  - Cycles with serdes_rx_hdr_valid=0 change nothing and do not break a run.
- Window end, on the qualified block where block counter == cfg_window-1:
  - Next cycle: result registers take the final counts, including this block.
  - high_ber is recomputed with cfg_thresh sampled at that edge.
  - done=1 for exactly one cycle.
  - If cfg_continuous=1: stay in RUN, working counters restart from 0, busy stays 1, no lost block. Otherwise go to IDLE, busy=0.
- busy=1 from the cycle after start is accepted until the cycle done pulses (non-continuous mode).
- Latency: done and results appear 1 cycle after the final qualifying rx_clk edge.
- Saturation: all counters stop at all-ones and never wrap. The block counter is WINDOW_WIDTH wide and cannot overflow because the window terminates first.
- cfg_* inputs are sampled at start and held internally for the window. cfg_thresh is the exception: it is sampled at window end.
- Result registers hold their value until the next done or reset.

Decomposition:
- Package eth_hdr_pkg:
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10.
  - FSM state localparams IDLE/RUN.
  - Function hdr_is_valid(hdr).
- Sub-module sat_counter (parameter WIDTH; inputs inc, clr; output q; saturates at all-ones). Instantiated for the valid, invalid and run counters.

Test Plan:
- cfg_window=100, start, 100 consecutive hdr=10 -> done 1 cycle after 100th block; valid_count=100, invalid_count=0, max_burst=0, high_ber=0.
- cfg_window=100, cfg_thresh=5, hdr=11 on every 10th block -> valid_count=90, invalid_count=10, max_burst=1, high_ber=1. Rerun with cfg_thresh=0 -> high_ber=0.
- Window 50 with hdr_valid toggling 1/0 and a burst of 7 consecutive 11 headers split by idle cycles -> invalid_count=7, max_burst=7, done after the 50th qualified block.
- cfg_continuous=1, cfg_window=20, 3 windows with 0, 2 and 20 errors -> three done pulses exactly 20 qualified blocks apart; busy stays 1; each pulse latches the matching counts.
- COUNT_WIDTH=4, cfg_window=40, all headers 00 -> invalid_count=15, max_burst=15, valid_count=0 (saturation, no wrap).
- Assert rx_rst after 30 blocks of a 100-block window -> all outputs 0 immediately; a subsequent start runs a clean window; start with cfg_window=0 leaves busy=0.
